// File: rtl/jsilicon_pkg.sv
// Shared opcodes, fetch state encoding and the power-on instruction image
// for the mode-1 fetch path.
package jsilicon_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } fetch_state_e;

    // Default program: ADD 3, SUB 2, MUL 5, NOP; everything else is NOP.
    function automatic logic [7:0] default_rom_word(input int unsigned addr);
        case (addr)
            0:       return {OP_ADD, 5'd3};
            1:       return {OP_SUB, 5'd2};
            2:       return {OP_MUL, 5'd5};
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/pc_rom_bank.sv
// Instruction store with combinational read. With PC_PROG_WRITE_EN defined it is a
// reset-loaded RAM with a write port; otherwise a constant ROM and the write port is dead.
module pc_rom_bank
    import jsilicon_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    logic raddr_ok;
    assign raddr_ok = {1'b0, raddr} < DEPTH_W;

`ifdef PC_PROG_WRITE_EN
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(default_rom_word(i));
        end else if (we && ({1'b0, waddr} < DEPTH_W)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read is combinational off the current array, so a same-edge write returns the old word.
    assign rdata = raddr_ok ? mem_q[raddr] : '0;
`else
    logic unused_wr;
    assign unused_wr = &{1'b0, clk, rst_n, we, waddr, wdata};

    assign rdata = raddr_ok ? DATA_W'(default_rom_word(32'(raddr))) : '0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC sequencer with wrap point, jump and halt/resume, presenting a registered
// instruction + valid strobe. Runtime program load enabled by PC_PROG_WRITE_EN.
module pc_fetch_unit
    import jsilicon_pkg::*;
#(
    parameter int          ADDR_W    = 4,
    parameter int          DATA_W    = 8,
    parameter int          DEPTH     = 16,
    parameter int          LAST_ADDR = 3,
    parameter logic [2:0]  HALT_OP   = OP_HALT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              resume,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata;

    pc_rom_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] p);
        return (p == LAST_A || p == END_A) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ena) begin
                    instr_d  = rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = next_pc(pc_q);
                    if (rdata[DATA_W-1 -: 3] == HALT_OP) state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) state_d = ST_RUN;
            end
        endcase
        // Jump overrides the sequential successor but never the fetch of the old pc.
        if (jump_en) pc_d = ({1'b0, jump_addr} < DEPTH_W) ? jump_addr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign pc_out      = pc_out_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == ST_HALT);

endmodule
